// File: rtl/adder_result_streamer_pkg.sv
// Shared constants and FSM state type for the adder result streamer.
package adder_stream_pkg;
  localparam int BYTE_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } stream_state_t;
endpackage

// File: rtl/adder_result_streamer_if.sv
// Byte-wide valid/ready stream carrying the adder result frame.
interface adder_stream_if;
  import adder_stream_pkg::*;

  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/adder_result_streamer_press_lock.sv
// Press lock: one trigger per start press; re-armed by the release button.
module press_lock (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic release_btn,
  input  logic arm_ok,
  output logic trigger
);
  logic lock;

  // Presses while a frame is running never reach the lock.
  assign trigger = start && !lock && arm_ok;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)           lock <= 1'b0;
    else if (trigger)     lock <= 1'b1;
    else if (release_btn) lock <= 1'b0;
  end
endmodule

// File: rtl/adder_result_streamer.sv
// Snapshots the adder sum on a start press and streams it LSB-first, one byte per transfer.
// Define ADDER_STREAM_CARRY_EN to append the carry-out as a final byte {7'b0, cout}.
// The button port is release_btn because "release" is a reserved SystemVerilog keyword.
module adder_result_streamer
  import adder_stream_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     release_btn,
  input  logic [BYTE_W*NBYTES-1:0] res_in,
  input  logic                     cout_in,
  adder_stream_if.master           stream,
  output logic                     busy,
  output logic [IDX_W-1:0]         byte_idx
);
`ifdef ADDER_STREAM_CARRY_EN
  localparam int FRAME_BYTES = NBYTES + 1;
`else
  localparam int FRAME_BYTES = NBYTES;
`endif
  localparam int             FRAME_W  = BYTE_W * FRAME_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  logic [FRAME_W-1:0] capture, shadow, src;
  stream_state_t      state, state_d;
  logic [IDX_W-1:0]   idx_d;
  logic [BYTE_W-1:0]  data_d;
  logic               valid_d, last_d, arm_ok, trigger;

`ifdef ADDER_STREAM_CARRY_EN
  assign capture = {{(BYTE_W-1){1'b0}}, cout_in, res_in};
`else
  logic unused_cout;
  assign capture     = res_in;
  assign unused_cout = cout_in;
`endif

  assign arm_ok = (state == S_IDLE);
  assign busy   = (state == S_SEND);

  press_lock u_press_lock (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .release_btn (release_btn),
    .arm_ok      (arm_ok),
    .trigger     (trigger)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    idx_d   = byte_idx;
    src     = shadow;
    case (state)
      S_IDLE: if (trigger) begin
        state_d = S_SEND;
        idx_d   = '0;
        src     = capture;  // shadow loads on this same edge, so byte 0 comes straight from the input
      end
      S_SEND: if (stream.out_ready) begin
        if (byte_idx == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = byte_idx + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_SEND);
    data_d  = valid_d ? src[BYTE_W*idx_d +: BYTE_W] : '0;
    last_d  = valid_d && (idx_d == LAST_IDX);
  end

  // NOTE: the shadow is a plain register, so it is reset along with the control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      shadow           <= '0;
      byte_idx         <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
    end else begin
      state            <= state_d;
      byte_idx         <= idx_d;
      stream.out_data  <= data_d;
      stream.out_valid <= valid_d;
      stream.out_last  <= last_d;
      if (trigger) shadow <= capture;
    end
  end
endmodule

// File: tb/tb_adder_result_streamer.sv
// Self-checking bench for adder_result_streamer: vector table plus lock and reset sequences.
module tb_adder_result_streamer;
`ifdef ADDER_STREAM_CARRY_EN
  localparam int FRAME_N = 5;
`else
  localparam int FRAME_N = 4;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] idx;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        cout;
    logic [39:0] exp;        // expected bytes, carry byte in [39:32]
    int          stall_at;   // byte index to stall on, -1 for none
    int          stall_len;  // stall cycles, negative for random ready
    bit          corrupt;    // change res_in/cout_in after capture
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, release_btn, cout_in, busy;
  logic [31:0] res_in;
  logic [2:0]  byte_idx;
  int          n_checks = 0, n_pass = 0, frames = 0;
  exp_t        sb[$];
  vec_t        vecs[6];

  adder_stream_if sif ();

  adder_result_streamer #(.NBYTES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .release_btn (release_btn),
    .res_in      (res_in),
    .cout_in     (cout_in),
    .stream      (sif),
    .busy        (busy),
    .byte_idx    (byte_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [39:0] exp);
    for (int i = 0; i < FRAME_N; i++) begin
      exp_t e;
      e.data = exp[8*i +: 8];
      e.last = (i == FRAME_N - 1);
      e.idx  = 3'(i);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_release();
    release_btn = 1'b1;
    step();
    release_btn = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_valid"}, sif.out_valid, 0);
    check({tag, "_last"},  sif.out_last, 0);
    check({tag, "_data"},  sif.out_data, 0);
    check({tag, "_idx"},   byte_idx, 0);
  endtask

  // Trigger one frame and drive ready per the vector until the stream goes idle.
  task automatic run_frame(input vec_t v);
    int  stalled = 0, valid_cyc = 0, stall_cyc = 0;
    bit  done = 0;
    sif.out_ready = 1'b1;
    res_in  = v.res;
    cout_in = v.cout;
    start   = 1'b1;
    push_frame(v.exp);
    step();
    start = 1'b0;
    if (v.corrupt) begin
      res_in  = 32'hFFFF_FFFF;
      cout_in = ~v.cout;
    end
    for (int t = 0; t < 100 && !done; t++) begin
      if (sif.out_valid) begin
        valid_cyc++;
        if (v.stall_len < 0) begin
          sif.out_ready = 1'($urandom_range(0, 1));
        end else if (int'(byte_idx) == v.stall_at && stalled < v.stall_len) begin
          sif.out_ready = 1'b0;
          stalled++;
          check({v.name, "_hold_data"}, sif.out_data, v.exp[8*v.stall_at +: 8]);
          check({v.name, "_hold_idx"}, byte_idx, 3'(v.stall_at));
        end else begin
          sif.out_ready = 1'b1;
        end
        if (!sif.out_ready) stall_cyc++;
        step();
      end else begin
        done = 1;
      end
    end
    sif.out_ready = 1'b1;
    check({v.name, "_done"}, done, 1);
    check({v.name, "_cycles"}, valid_cyc, FRAME_N + stall_cyc);
    check({v.name, "_sb_empty"}, sb.size(), 0);
    check_idle(v.name);
  endtask

  // Scoreboard: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sif.out_valid && sif.out_ready) begin
      check("sb_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("byte_data", sif.out_data, e.data);
        check("byte_last", sif.out_last, e.last);
        check("byte_idx",  byte_idx, e.idx);
        if (e.last) frames++;
      end
    end
  end

  initial begin
    int   f0;
    bit   busy_seen;
    bit   reached;
    vec_t lock_v;

    vecs[0] = '{"basic",     32'hDEADBEEF, 1'b1, 40'h01_DEADBEEF, -1,  0, 1'b0};
    vecs[1] = '{"backpress", 32'h04030201, 1'b0, 40'h00_04030201,  1,  3, 1'b0};
    vecs[2] = '{"zeros",     32'h00000000, 1'b1, 40'h01_00000000, -1,  0, 1'b0};
    vecs[3] = '{"isolate",   32'hA5C31E77, 1'b0, 40'h00_A5C31E77, -1,  0, 1'b1};
    vecs[4] = '{"random",    32'h80000001, 1'b1, 40'h01_80000001, -1, -1, 1'b0};
    vecs[5] = '{"last_stall",32'h0F1E2D3C, 1'b1, 40'h01_0F1E2D3C, FRAME_N-1, 2, 1'b0};

    rst_n = 1'b0; start = 1'b0; release_btn = 1'b0;
    res_in = '0; cout_in = 1'b0; sif.out_ready = 1'b1;
    step();
    step();
    check_idle("reset");
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      pulse_release();
      run_frame(vecs[i]);
    end

    // start held for 20 cycles yields one frame
    pulse_release();
    f0 = frames;
    res_in = 32'h13579BDF; cout_in = 1'b0;
    start = 1'b1;
    push_frame(40'h00_13579BDF);
    repeat (20) step();
    start = 1'b0;
    step();
    check("hold_start_frames", frames - f0, 1);
    check("hold_start_sb", sb.size(), 0);

    // a second press without release is ignored
    f0 = frames;
    busy_seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) begin
      if (busy || sif.out_valid) busy_seen = 1;
      step();
    end
    check("locked_no_frame", busy_seen, 0);
    check("locked_frames", frames - f0, 0);

    // release then start gives a second frame
    lock_v = '{"rearm", 32'hCAFE0042, 1'b1, 40'h01_CAFE0042, -1, 0, 1'b0};
    f0 = frames;
    pulse_release();
    run_frame(lock_v);
    check("rearm_frames", frames - f0, 1);

    // reset during byte 2 abandons the frame and clears the lock
    pulse_release();
    res_in = 32'h44332211; cout_in = 1'b1;
    start = 1'b1;
    push_frame(40'h01_44332211);
    step();
    start = 1'b0;
    reached = 0;
    for (int t = 0; t < 20 && !reached; t++) begin
      if (sif.out_valid && byte_idx == 3'd2) reached = 1;
      else step();
    end
    check("reach_byte2", reached, 1);
    check("byte2_data", sif.out_data, 8'h33);
    rst_n = 1'b0;
    sif.out_ready = 1'b0;
    step();
    check_idle("midreset");
    sb.delete();
    rst_n = 1'b1;
    lock_v = '{"post_reset", 32'h5A6B7C8D, 1'b0, 40'h00_5A6B7C8D, -1, 0, 1'b0};
    run_frame(lock_v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adder_result_streamer.md
# adder_result_streamer

Output-side companion to the byte-wise operand loader of the 32-bit adder. On a debounced `start` press it snapshots the 32-bit sum and carry-out. It then streams the snapshot out LSB-first, one byte per transfer, over an 8-bit valid/ready interface. It sits between the adder's `sum`/`cout` and the board's byte-wide output path, replacing static `select`-driven byte viewing with a sequenced frame.

## Interface
Parameters:
- `NBYTES`, default 4: number of data bytes per frame. Legal range is 1..4; the data width is 8*`NBYTES`.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  button level; requests a frame.
- `release`  in  1  button level; re-arms the press lock.
- `res_in`  in  8*`NBYTES`  adder sum.
- `cout_in`  in  1  adder carry-out.
- `out_data`  out  8  current byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  the sink accepts the byte.
- `out_last`  out  1  the current byte is the final byte of the frame.
- `busy`  out  1  a frame is in progress.
- `byte_idx`  out  3  index of the current byte.

## Operation
- States (FSM): `S_IDLE` and `S_SEND`.
- Press lock: a trigger occurs when `start`=1, `lock`=0 and the FSM is in `S_IDLE`.
  - A trigger sets `lock` to 1.
  - Otherwise, if `release`=1, `lock` is cleared to 0.
  - When both occur in the same cycle, the trigger has priority.
  - `start`=1 while `busy`=1 is ignored and does not change `lock`.
- Trigger: on the triggering edge the block latches `res_in` and `cout_in` into a shadow register, sets `byte_idx` to 0, and moves to `S_SEND`.
- `S_SEND` outputs:
  - `out_valid`=1.
  - `out_data` = `shadow[8*byte_idx +: 8]`.
  - `out_last` = 1 when `byte_idx` = LASTIDX.
- Transfer: a byte is transferred on any edge where `out_valid`=1 and `out_ready`=1.
  - If it is not the last byte, `byte_idx` increments.
  - If it is the last byte, the FSM moves to `S_IDLE`, `out_valid` goes to 0 and `byte_idx` goes to 0.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `byte_idx` hold stable.
- `res_in` changes after capture do not affect the frame in flight.
- `busy` = (state == `S_SEND`).
- LASTIDX is `NBYTES`-1, or `NBYTES` when the carry byte is enabled (see Configuration).

## Timing
- All outputs are registered.
- Reset value of every output is 0: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `byte_idx`=0. Reset also sets `lock`=0, the shadow register to 0, and the FSM to `S_IDLE`.
- Latency: if the trigger is sampled at edge N, `out_valid` is 1 in the cycle after edge N and carries byte 0.
- With `out_ready` held at 1, the frame occupies LASTIDX+1 consecutive cycles.
- `busy` falls on the edge that accepts the last byte.
- The earliest next trigger is one edge later, and only after `release` has cleared `lock`.
- Reset asserted mid-frame abandons the frame on that edge. No `out_last` is issued, and the lock is re-armed.
- `start` held high across the whole frame produces exactly one frame.

## Configuration
- Macro `ADDER_STREAM_CARRY_EN`.
- Defined: the frame has `NBYTES`+1 bytes. The final byte at index `NBYTES` is {7'b0, captured `cout_in`}, and `out_last` is asserted on that byte.
- Undefined: the frame has `NBYTES` bytes, `cout_in` is not captured, and `out_last` is asserted on byte `NBYTES`-1.

## Structure
- Shared package `adder_stream_pkg`:
  - `BYTE_W`=8.
  - State enum `stream_state_t` with values `S_IDLE` and `S_SEND`.
  - Constant `IDX_W`=3.
- Sub-module `press_lock`:
  - Inputs: `clk`, `rst_n`, `start`, `release`, `arm_ok`, where `arm_ok` is the top-level `S_IDLE` condition.
  - Output: a one-cycle `trigger` pulse.
  - Implements the lock rules above.
- The top level `adder_result_streamer` holds the FSM, the shadow register and the byte mux.

## Test plan
- Basic frame:
  - Stimulus: `ADDER_STREAM_CARRY_EN` defined, `res_in`=32'hDEADBEEF, `cout_in`=1, `out_ready`=1, one `start` press.
  - Required: bytes EF, BE, AD, DE, 01 on consecutive cycles, with `out_last` asserted only on 01.
- Carry byte compiled out:
  - Stimulus: same as the basic frame, macro undefined.
  - Required: bytes EF, BE, AD, DE, with `out_last` asserted on DE.
- Backpressure:
  - Stimulus: `res_in`=32'h04030201, `out_ready` low for 3 cycles while byte 02 is presented.
  - Required: 02 held stable with `byte_idx`=1. No byte is dropped or duplicated, and the sink receives 01 02 03 04.
- Lock behaviour:
  - Stimulus: `start` held high for 20 cycles.
  - Required: exactly one frame.
  - Stimulus: `start` pulsed again without `release`.
  - Required: no frame.
  - Stimulus: `release` pulse, then `start`.
  - Required: a second frame.
- Capture isolation:
  - Stimulus: `res_in` changed to 32'hFFFFFFFF mid-frame.
  - Required: the original bytes continue to be streamed.
- Reset mid-frame:
  - Stimulus: `rst_n`=0 during byte 2.
  - Required: on the next edge every output is 0 and `busy`=0. A new `start` without `release` then triggers a frame, because reset cleared the lock.
